// File: rtl/mem_access_stage.sv
// mem_access_stage: EX->MEM->WB pipeline stage.
// Registers EX results, runs a multi-cycle data-memory access with a ready
// handshake and a watchdog, stalls upstream while busy, and presents a
// registered write-back bundle to the register file.
module mem_access_stage #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [REG_AW-1:0] ex_dst_reg,
  input  logic              ex_reg_write,
  input  logic              ex_hlt,
  output logic              mem_stall,
  output logic              dmem_en,
  output logic              dmem_wr,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0] wb_dst_reg,
  output logic              wb_reg_write,
  output logic              wb_hlt,
  output logic              mem_err
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [REG_AW-1:0] lat_dst;
  logic              lat_reg_write;
  logic              lat_hlt;
  logic              mem_op;
  logic              finish;
  logic              abort;

  assign mem_op = ex_valid & (ex_mem_read | ex_mem_write);

  // Access completion and watchdog decode for the current cycle
  always_comb begin
    cnt_next = cnt + CNT_W'(1);
    finish   = 1'b0;
    abort    = 1'b0;
    case (state)
      S_REQ:   finish = dmem_ready;
      S_WAIT: begin
        abort  = !dmem_ready && (cnt_next == CNT_W'(MAX_WAIT));
        finish = dmem_ready || abort;
      end
      default: begin
        finish = 1'b0;
        abort  = 1'b0;
      end
    endcase
  end

  // Upstream hold: combinational so EX freezes in the same cycle a mem op is seen
  assign mem_stall = !rst && (((state == S_IDLE) && mem_op) ||
                              (state == S_REQ) || (state == S_WAIT));

  // Stage FSM with registered memory-request and write-back outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      lat_dst       <= '0;
      lat_reg_write <= 1'b0;
      lat_hlt       <= 1'b0;
      dmem_en       <= 1'b0;
      dmem_wr       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      wb_valid      <= 1'b0;
      wb_data       <= '0;
      wb_dst_reg    <= '0;
      wb_reg_write  <= 1'b0;
      wb_hlt        <= 1'b0;
      mem_err       <= 1'b0;
    end else begin
      dmem_en <= 1'b0;
      mem_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mem_op) begin
            state         <= S_REQ;
            dmem_en       <= 1'b1;
            dmem_wr       <= ex_mem_write;
            dmem_addr     <= ex_alu_out;
            dmem_wdata    <= ex_store_data;
            lat_dst       <= ex_dst_reg;
            lat_reg_write <= ex_reg_write;
            lat_hlt       <= ex_hlt;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
          end else begin
            wb_valid     <= ex_valid;
            wb_data      <= ex_alu_out;
            wb_dst_reg   <= ex_dst_reg;
            wb_reg_write <= ex_valid & ex_reg_write;
            wb_hlt       <= wb_hlt | (ex_valid & ex_hlt);
          end
        end
        S_REQ, S_WAIT: begin
          if (finish) begin
            state      <= S_DONE;
            cnt        <= '0;
            wb_valid   <= 1'b1;
            wb_dst_reg <= lat_dst;
            wb_hlt     <= wb_hlt | lat_hlt;
            mem_err    <= abort;
            // Stores and aborted accesses never write the register file
            if (abort || dmem_wr) begin
              wb_reg_write <= 1'b0;
              wb_data      <= dmem_addr;
            end else begin
              wb_reg_write <= lat_reg_write;
              wb_data      <= dmem_rdata;
            end
          end else if (state == S_REQ) begin
            state <= S_WAIT;
            cnt   <= '0;
          end else begin
            cnt <= cnt_next;
          end
        end
        S_DONE: begin
          state        <= S_IDLE;
          wb_valid     <= 1'b0;
          wb_reg_write <= 1'b0;
          dmem_wr      <= 1'b0;
          dmem_addr    <= '0;
          dmem_wdata   <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
